// File: rtl/tjmono_arb_pkg.sv
// Shared types and constants for the tjmono stream arbiters.
// Holds the FSM state encoding, datapath widths and a saturating counter helper.
package tjmono_arb_pkg;

  localparam int WORD_W  = 32;
  localparam int ABORT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ABORT_W-1:0] sat_inc(input logic [ABORT_W-1:0] v);
    return (v == {ABORT_W{1'b1}}) ? v : v + {{(ABORT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/tjmono_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requesting index after 'last', wrapping modulo N.
module tjmono_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N; k >= 1; k--) begin
      cand     = (int'(last) + k) % N;
      cand_idx = cand[IDX_W-1:0];
      found    = req[cand_idx] ? 1'b1 : found;
      idx      = req[cand_idx] ? cand_idx : idx;
    end
  end

endmodule

// File: rtl/tjmono_rx_arbiter.sv
// Packet-atomic round-robin merge of N_IN FWFT source FIFOs into one FWFT stream.
// A granted source keeps the grant for a full packet unless it stalls for TIMEOUT cycles.
module tjmono_rx_arbiter
  import tjmono_arb_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int PACKET_WORDS = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST_N,
  input  logic [N_IN-1:0]          ENABLE,
  input  logic [N_IN-1:0]          IN_FIFO_EMPTY,
  input  logic [WORD_W*N_IN-1:0]   IN_FIFO_DATA,
  output logic [N_IN-1:0]          IN_FIFO_READ,
  input  logic                     FIFO_READ,
  output logic                     FIFO_EMPTY,
  output logic [WORD_W-1:0]        FIFO_DATA,
  output logic                     BUSY,
  output logic [ABORT_W-1:0]       ABORT_CNT
);

  localparam int IDX_W   = $clog2(N_IN);
  localparam int WCNT_W  = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
  localparam int STALL_W = 8;

  localparam logic [IDX_W-1:0]   LAST_GRANT_RST = IDX_W'(N_IN - 1);
  localparam logic [WCNT_W-1:0]  LAST_WORD      = WCNT_W'(PACKET_WORDS - 1);
  localparam logic [WCNT_W-1:0]  WCNT_ONE       = {{(WCNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_W-1:0] STALL_LAST     = STALL_W'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [ABORT_W-1:0]  abort_cnt_q, abort_cnt_d;
  logic                out_empty_q, out_empty_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;

  logic [N_IN-1:0]     req_s;
  logic                pick_found_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                src_empty_s;
  logic [WORD_W-1:0]   src_word_s;
  logic                slot_free_s;
  logic                pop_s;

  assign req_s = ENABLE & ~IN_FIFO_EMPTY;

  tjmono_rr_pick #(
    .N     (N_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_s),
    .last  (last_grant_q),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Granted source view and the pop decision.
  always_comb begin
    src_empty_s = IN_FIFO_EMPTY[grant_q];
    src_word_s  = '0;
    for (int i = 0; i < N_IN; i++) begin
      src_word_s = (grant_q == IDX_W'(i)) ? IN_FIFO_DATA[i*WORD_W +: WORD_W] : src_word_s;
    end
    slot_free_s  = out_empty_q | FIFO_READ;
    pop_s        = (state_q == ST_LOCKED) & ~src_empty_s & slot_free_s;
    IN_FIFO_READ = '0;
    if (pop_s) begin
      IN_FIFO_READ[grant_q] = 1'b1;
    end else begin
      IN_FIFO_READ = '0;
    end
  end

  // Grant FSM, packet word counter and stall watchdog.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d     = ST_LOCKED;
          grant_d     = pick_idx_s;
          word_cnt_d  = '0;
          stall_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (pop_s) begin
          stall_cnt_d = '0;
          if (word_cnt_q == LAST_WORD) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
            word_cnt_d   = '0;
          end else begin
            word_cnt_d = word_cnt_q + WCNT_ONE;
          end
        end else if (src_empty_s) begin
          if (stall_cnt_q == STALL_LAST) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
            word_cnt_d   = '0;
            stall_cnt_d  = '0;
            abort_cnt_d  = sat_inc(abort_cnt_q);
          end else begin
            stall_cnt_d = stall_cnt_q + 8'd1;
          end
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        word_cnt_d  = '0;
        stall_cnt_d = '0;
      end
    endcase
  end

  // Output holding register: a load wins over a pop, a bare pop empties it.
  always_comb begin
    out_empty_d = out_empty_q;
    out_data_d  = out_data_q;
    if (pop_s) begin
      out_empty_d = 1'b0;
      out_data_d  = src_word_s;
    end else if (FIFO_READ && !out_empty_q) begin
      out_empty_d = 1'b1;
    end else begin
      out_empty_d = out_empty_q;
    end
  end

  // State registers.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_GRANT_RST;
      word_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      abort_cnt_q  <= '0;
      out_empty_q  <= 1'b1;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
      out_empty_q  <= out_empty_d;
      out_data_q   <= out_data_d;
    end
  end

  assign FIFO_EMPTY = out_empty_q;
  assign FIFO_DATA  = out_data_q;
  assign BUSY       = (state_q == ST_LOCKED);
  assign ABORT_CNT  = abort_cnt_q;

endmodule

// File: tb/tb_tjmono_rx_arbiter.sv
// Bench for tjmono_rx_arbiter: source FIFOs are bench queues, expectations come
// from a packet-level round-robin model and the documented cycle timing.
module tb_tjmono_rx_arbiter;

  localparam int N  = 4;
  localparam int PW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  en;
  logic [N-1:0]  in_empty;
  logic [32*N-1:0] in_data;
  logic [N-1:0]  in_read;
  logic          fifo_read;
  logic          fifo_empty;
  logic [31:0]   fifo_data;
  logic          busy;
  logic [7:0]    abort_cnt;

  tjmono_rx_arbiter #(
    .N_IN         (N),
    .PACKET_WORDS (PW),
    .TIMEOUT      (TO)
  ) dut (
    .BUS_CLK       (clk),
    .BUS_RST_N     (rst_n),
    .ENABLE        (en),
    .IN_FIFO_EMPTY (in_empty),
    .IN_FIFO_DATA  (in_data),
    .IN_FIFO_READ  (in_read),
    .FIFO_READ     (fifo_read),
    .FIFO_EMPTY    (fifo_empty),
    .FIFO_DATA     (fifo_data),
    .BUSY          (busy),
    .ABORT_CNT     (abort_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] srcq [N][$];
  logic [31:0] got [$];
  int          pop_src [$];
  int          n_checks = 0, n_pass = 0, n_fail = 0, n_timeouts = 0;
  int          rd_pct = 100, model_last = N - 1;
  int          cyc = 0, first_pop = -1, last_pop = -1;
  logic [N-1:0] s_rd;
  logic        s_empty, s_busy, s_fr;
  logic [31:0] s_data;
  logic [7:0]  s_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_empty[i] = (srcq[i].size() == 0);
      if (srcq[i].size() != 0) in_data[32*i +: 32] = srcq[i][0];
      else in_data[32*i +: 32] = 32'h0;
    end
    fifo_read = (int'($urandom_range(99, 0)) < rd_pct);
  endtask

  // One clock: drive, sample at negedge, then apply pops seen by the DUT.
  task automatic tick();
    logic [31:0] tmp;
    drive();
    @(negedge clk);
    s_rd = in_read; s_empty = fifo_empty; s_data = fifo_data;
    s_busy = busy; s_abort = abort_cnt; s_fr = fifo_read;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (s_rd[i]) begin
        if (srcq[i].size() != 0) tmp = srcq[i].pop_front();
        pop_src.push_back(i);
      end
    end
    if (s_rd != '0) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (s_fr && !s_empty) got.push_back(s_data);
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) srcq[i].delete();
    got.delete();
    pop_src.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    in_empty = '1;
    fifo_read = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_last = N - 1;
  endtask

  // Load whole packets, predict the merged stream at packet level, run and compare.
  task automatic run_pkts(input int c0, input int c1, input int c2, input int c3,
                          input int pct, input string tag);
    int          cnt [N];
    int          rem [N];
    logic [31:0] pk [N][$];
    logic [31:0] exp_w [$];
    int          exp_s [$];
    logic [31:0] w;
    int          last, sel, j, guard, lim;
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    got.delete(); pop_src.delete(); first_pop = -1;
    for (int i = 0; i < N; i++) begin
      rem[i] = cnt[i];
      for (int p = 0; p < cnt[i] * PW; p++) begin
        w = $urandom;
        srcq[i].push_back(w);
        pk[i].push_back(w);
      end
    end
    last = model_last;
    forever begin
      sel = -1;
      for (int k = 1; k <= N; k++) begin
        j = (last + k) % N;
        if (sel < 0 && rem[j] > 0 && en[j]) sel = j;
      end
      if (sel < 0) break;
      for (int p = 0; p < PW; p++) begin
        exp_w.push_back(pk[sel].pop_front());
        exp_s.push_back(sel);
      end
      rem[sel]--;
      last = sel;
    end
    model_last = last;
    rd_pct = pct;
    guard = 0;
    while (got.size() < exp_w.size() && guard < 3000) begin
      tick();
      guard++;
    end
    if (guard >= 3000) n_timeouts++;
    chk({tag, "_words"}, 32'(got.size()), 32'(exp_w.size()));
    chk({tag, "_pops"}, 32'(pop_src.size()), 32'(exp_s.size()));
    lim = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
    for (int k = 0; k < lim; k++) chk({tag, "_data"}, got[k], exp_w[k]);
    lim = (pop_src.size() < exp_s.size()) ? pop_src.size() : exp_s.size();
    for (int k = 0; k < lim; k++) chk({tag, "_src"}, 32'(pop_src[k]), 32'(exp_s[k]));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [N-1:0]  r_rd [8];
    logic          r_em [8];
    logic          r_bu [8];
    logic [31:0]   r_da [8];
    logic [31:0]   pk1 [$];
    logic [31:0]   pk3 [$];
    logic [31:0]   w;
    int            guard, stall, exp_ab;

    rst_n = 1'b1; en = '1; in_empty = '1; in_data = '0; fifo_read = 1'b0;
    do_reset();

    // Reset state with all sources empty.
    tick();
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_data", s_data, 32'h0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_abort", 32'(s_abort), 32'd0);
    chk("rst_rd", 32'(s_rd), 32'd0);

    // Single source, downstream always popping.
    rd_pct = 100;
    got.delete(); pop_src.delete();
    for (int k = 1; k <= 4; k++) srcq[0].push_back(32'hC000_0000 + 32'(k));
    for (int t = 0; t < 8; t++) begin
      tick();
      r_rd[t] = s_rd; r_em[t] = s_empty; r_bu[t] = s_busy; r_da[t] = s_data;
    end
    chk("single_rd_t0", 32'(r_rd[0]), 32'd0);
    chk("single_rd_t1", 32'(r_rd[1]), 32'd1);
    chk("single_empty_t1", 32'(r_em[1]), 32'd1);
    chk("single_empty_t2", 32'(r_em[2]), 32'd0);
    for (int k = 0; k < 4; k++) chk("single_data", r_da[2+k], 32'hC000_0001 + 32'(k));
    chk("single_busy_t4", 32'(r_bu[4]), 32'd1);
    chk("single_busy_t5", 32'(r_bu[5]), 32'd0);
    chk("single_empty_t6", 32'(r_em[6]), 32'd1);
    chk("single_pops", 32'(pop_src.size()), 32'd4);

    // Fairness: 2 packets per source, order 0,1,2,3,0,1,2,3 with one idle cycle per turnaround.
    do_reset();
    run_pkts(2, 2, 2, 2, 100, "fair");
    chk("fair_span", 32'(last_pop - first_pop + 1), 32'(8 * PW + 7));

    // Random packet counts with random downstream backpressure.
    for (int r = 0; r < 3; r++) begin
      run_pkts(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
               int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
               int'($urandom_range(100, 30)), "rand");
    end
    chk("rand_abort", 32'(s_abort), 32'd0);

    // Backpressure: downstream frozen for 20 cycles mid-packet must not trip the watchdog.
    got.delete(); pop_src.delete(); pk1.delete();
    for (int k = 0; k < PW; k++) begin
      w = $urandom;
      srcq[1].push_back(w);
      pk1.push_back(w);
    end
    rd_pct = 100;
    guard = 0;
    while (pop_src.size() < 2 && guard < 50) begin tick(); guard++; end
    if (guard >= 50) n_timeouts++;
    rd_pct = 0;
    repeat (20) tick();
    chk("bp_locked", 32'(s_busy), 32'd1);
    chk("bp_abort_mid", 32'(s_abort), 32'd0);
    rd_pct = 100;
    guard = 0;
    while (got.size() < PW && guard < 50) begin tick(); guard++; end
    if (guard >= 50) n_timeouts++;
    repeat (3) tick();
    chk("bp_words", 32'(got.size()), 32'(PW));
    for (int k = 0; k < PW && k < got.size(); k++) chk("bp_data", got[k], pk1[k]);
    chk("bp_abort_end", 32'(s_abort), 32'd0);

    // Enable mask 1010; drop ENABLE[1] after its first pop, packet must still complete.
    do_reset();
    en = 4'b1010;
    pk1.delete(); pk3.delete();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < PW; k++) begin
        w = $urandom;
        srcq[i].push_back(w);
        if (i == 1) pk1.push_back(w);
        if (i == 3) pk3.push_back(w);
      end
    end
    rd_pct = 100;
    guard = 0;
    while (pop_src.size() < 1 && guard < 20) begin tick(); guard++; end
    if (guard >= 20) n_timeouts++;
    en = 4'b1000;
    guard = 0;
    while (got.size() < 2 * PW && guard < 100) begin tick(); guard++; end
    if (guard >= 100) n_timeouts++;
    repeat (10) tick();
    chk("en_first_src", 32'(pop_src[0]), 32'd1);
    chk("en_words", 32'(got.size()), 32'(2 * PW));
    for (int k = 0; k < PW && k < got.size(); k++) chk("en_pkt1", got[k], pk1[k]);
    for (int k = 0; k < PW && PW + k < got.size(); k++) chk("en_pkt3", got[PW+k], pk3[k]);
    chk("en_src0_left", 32'(srcq[0].size()), 32'(PW));
    chk("en_src2_left", 32'(srcq[2].size()), 32'(PW));

    // Watchdog: source 2 dries up after 2 words, then source 3 is served.
    do_reset();
    en = '1;
    pk1.delete(); pk3.delete();
    for (int k = 0; k < 2; k++) begin w = $urandom; srcq[2].push_back(w); pk1.push_back(w); end
    for (int k = 0; k < PW; k++) begin w = $urandom; srcq[3].push_back(w); pk3.push_back(w); end
    rd_pct = 100;
    guard = 0;
    while (pop_src.size() < 2 && guard < 20) begin tick(); guard++; end
    if (guard >= 20) n_timeouts++;
    stall = 0;
    guard = 0;
    forever begin
      tick();
      guard++;
      if (!s_busy || guard >= 50) break;
      stall++;
    end
    if (guard >= 50) n_timeouts++;
    chk("wd_stall_cycles", 32'(stall), 32'(TO));
    chk("wd_abort_cnt", 32'(s_abort), 32'd1);
    guard = 0;
    while (got.size() < 2 + PW && guard < 50) begin tick(); guard++; end
    if (guard >= 50) n_timeouts++;
    chk("wd_words", 32'(got.size()), 32'(2 + PW));
    for (int k = 0; k < 2 && k < got.size(); k++) chk("wd_partial", got[k], pk1[k]);
    for (int k = 0; k < PW && 2 + k < got.size(); k++) chk("wd_next", got[2+k], pk3[k]);
    if (pop_src.size() > 2) chk("wd_next_src", 32'(pop_src[2]), 32'd3);
    else chk("wd_next_src_seen", 32'(pop_src.size()), 32'd3);

    // Abort saturation: many single-word packets on source 0.
    exp_ab = 1;
    got.delete(); pop_src.delete();
    for (int n = 0; n < 260; n++) begin
      srcq[0].push_back($urandom);
      guard = 0;
      do begin tick(); guard++; end while (!s_busy && guard < 20);
      if (guard >= 20) n_timeouts++;
      guard = 0;
      do begin tick(); guard++; end while (s_busy && guard < 40);
      if (guard >= 40) n_timeouts++;
      exp_ab = (exp_ab >= 255) ? 255 : exp_ab + 1;
      if (n == 9) chk("sat_abort_mid", 32'(s_abort), 32'(exp_ab));
    end
    repeat (3) tick();
    chk("sat_abort_end", 32'(s_abort), 32'(exp_ab));
    chk("sat_words", 32'(got.size()), 32'd260);

    // Reset mid-packet with the output register full.
    got.delete(); pop_src.delete();
    for (int k = 0; k < PW; k++) srcq[0].push_back($urandom);
    rd_pct = 100;
    guard = 0;
    while (pop_src.size() < 2 && guard < 20) begin tick(); guard++; end
    if (guard >= 20) n_timeouts++;
    rd_pct = 0;
    tick();
    chk("mid_pre_full", 32'(fifo_empty), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
    chk("mid_rst_data", fifo_data, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rd", 32'(in_read), 32'd0);
    chk("mid_rst_abort", 32'(abort_cnt), 32'd0);
    flush();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) for (int k = 0; k < PW; k++) srcq[i].push_back($urandom);
    rd_pct = 100;
    guard = 0;
    while (pop_src.size() < 1 && guard < 20) begin tick(); guard++; end
    if (guard >= 20) n_timeouts++;
    if (pop_src.size() > 0) chk("mid_next_grant", 32'(pop_src[0]), 32'd0);
    else chk("mid_next_grant_seen", 32'(pop_src.size()), 32'd1);

    chk("wait_bounds", 32'(n_timeouts), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tjmono_rx_arbiter.md
# tjmono_rx_arbiter

Round-robin, packet-atomic arbiter that merges up to N `tjmono_data_rx` output FIFO streams into one 32-bit FWFT stream for the shared host readout FIFO/SiTCP path.
- Each hit record is a fixed group of PACKET_WORDS words.
- Once a source is granted, its whole packet is forwarded contiguously before any other source is served.
- A stall watchdog releases a source that dries up mid-packet.

## Interface
Parameters:
- N_IN, 4 — number of source streams (2..8).
- PACKET_WORDS, 4 — words per hit record; grant is held for exactly this many transfers.
- TIMEOUT, 255 — consecutive source-empty cycles tolerated mid-packet before abort (1..255).

Ports:
- BUS_CLK  in  1  sole clock.
- BUS_RST_N  in  1  reset, asynchronous, active-low.
- ENABLE  in  N_IN  per-source participation mask; sampled only when a grant is made.
- IN_FIFO_EMPTY  in  N_IN  source empty flags.
- IN_FIFO_DATA  in  32*N_IN  source data; source i at [32*i+31:32*i]; valid while its EMPTY is low (FWFT).
- IN_FIFO_READ  out  N_IN  one-cycle pop strobe per source; combinational.
- FIFO_READ  in  1  downstream pop.
- FIFO_EMPTY  out  1  low while the output register holds a word.
- FIFO_DATA  out  32  output word; passes source words unmodified.
- BUSY  out  1  high in LOCKED state.
- ABORT_CNT  out  8  saturating count of watchdog aborts.

## Operation
- State machine states are IDLE and LOCKED.
- IDLE: the picker searches for the first source i with ENABLE[i] and !IN_FIFO_EMPTY[i], starting at (last_grant+1) mod N_IN and wrapping.
  - If one is found, register grant=i and go to LOCKED. No transfer happens in IDLE.
  - If none is found, stay in IDLE.
- LOCKED:
  - slot_free = FIFO_EMPTY | FIFO_READ.
  - IN_FIFO_READ[grant] = !IN_FIFO_EMPTY[grant] & slot_free. All other bits are 0.
  - On a pop, the output register loads the word and word_cnt increments.
  - When word_cnt reaches PACKET_WORDS: return to IDLE, set last_grant=grant, clear word_cnt.
- Watchdog:
  - stall_cnt increments each LOCKED cycle in which IN_FIFO_EMPTY[grant]=1, and clears on every pop.
  - Cycles blocked only by a full output (slot not free) do not count.
  - When stall_cnt reaches TIMEOUT: go to IDLE, set last_grant=grant, increment ABORT_CNT (saturates at 255). The partial packet already forwarded is not retracted.
- An ENABLE[grant] deassert while LOCKED has no effect; the packet completes.
- Output register:
  - FIFO_READ while FIFO_EMPTY=1 is ignored.
  - A simultaneous pop and load keeps FIFO_EMPTY low and replaces the data.
  - A pop with no load sets FIFO_EMPTY high.
- Reset, asynchronous and at any time including mid-packet:
  - state=IDLE, grant=0, last_grant=N_IN-1 (first search starts at source 0).
  - word_cnt=0, stall_cnt=0, ABORT_CNT=0.
  - FIFO_EMPTY=1, FIFO_DATA=0, BUSY=0, IN_FIFO_READ=0.
  - Any word held in the output register is discarded.

## Timing
- Source i non-empty and selected at cycle t: state=LOCKED at t+1; IN_FIFO_READ[i] high at t+1; FIFO_EMPTY low at t+2.
- Steady state: 1 word/cycle while the source is non-empty and downstream pops every cycle.
- Packet turnaround: one IDLE cycle between consecutive packets. Peak efficiency is PACKET_WORDS/(PACKET_WORDS+1).
- Abort takes effect on the cycle after stall_cnt reaches TIMEOUT.
- No combinational path from FIFO_DATA/FIFO_EMPTY back to the inputs.
- IN_FIFO_READ depends combinationally on IN_FIFO_EMPTY and FIFO_READ.

## Structure
- Shared package `tjmono_arb_pkg`:
  - state enum (IDLE, LOCKED);
  - the 32-bit word width constant;
  - the ABORT_CNT width constant.
- One sub-module, `tjmono_rr_pick`: combinational, takes the request mask and last_grant, returns found and index. It is reused by future trigger/TDC stream mergers.
- All sequential logic stays in the top module.

## Test plan
- Single source: source 0 holds words 0xC0000001..0xC0000004, downstream always popping. Required: IN_FIFO_READ[0] asserts 1 cycle after the source goes non-empty; FIFO_DATA shows the 4 words in order starting 2 cycles after it; BUSY returns low after the 4th pop.
- Fairness: sources 0–3 each hold 2 packets, all enabled. Required: grant order 0,1,2,3,0,1,2,3; no interleaving of words within a packet; one idle cycle between packets.
- Backpressure: FIFO_READ held low for 20 cycles mid-packet with TIMEOUT=8. Required: no abort, ABORT_CNT stays 0, no word lost or duplicated.
- Watchdog: source 2 delivers 2 of 4 words and then stays empty, TIMEOUT=8. Required: ABORT_CNT=1 after 8 stall cycles, then source 3 is granted. Also check 256 aborts leave ABORT_CNT=255.
- Enable mask: ENABLE=4'b1010 with all sources non-empty → only sources 1 and 3 are served. Deassert ENABLE[1] mid-packet → that packet still completes.
- Reset mid-packet: BUS_RST_N low after 2 words with the output register full. Required: all outputs immediately at their reset values, and the next grant after release goes to source 0.
